hazard_unit: RTL and testbench

- Control-side producer of the stall_flag and branch_flag consumed by the IF/ID/EX pipeline registers of the 5-stage RV32I core.
- Detects load-use hazards between the ID and EX stages and stretches the stall over STALL_CYCLES.
- Resolves branches in the MEM stage and issues the flush plus the redirect PC.
- Keeps saturating stall and flush event counters for debug.

---
 rtl/core_pkg.sv | 33 +++
 rtl/hazard_unit_sat_counter.sv | 28 ++
 rtl/hazard_unit.sv | 153 +++++++++++++++
 tb/tb_hazard_unit.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared types and constants for the RV32I core control path:
//               hazard FSM state encoding, register-file address width,
//               x0 index and the write-back select encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

  // Hazard unit FSM states
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } hazard_state_t;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

  // Write-back source select; WB_SEL_MEM marks a load in EX
  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;

  // True when a producer register is a real (non-x0) match for a consumer
  function automatic logic reg_dep(input logic [REG_ADDR_W-1:0] rd,
                                   input logic [REG_ADDR_W-1:0] rs);
    return (rd != REG_X0) && (rd == rs);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_unit_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that saturates at all-ones instead of wrapping.
//               Synchronous active-high reset and synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] value
);

  // Count up on inc, holding once all bits are set
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      value <= '0;
    end else if (inc && (value != {WIDTH{1'b1}})) begin
      value <= value + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit
// Description : Load-use stall and MEM-stage branch flush control for the
//               5-stage RV32I pipeline, with saturating debug counters.
//               Flags are combinational so the pipeline registers act on them
//               at the same clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_unit
  import core_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_read_addr_1,
  input  logic [REG_ADDR_W-1:0] id_read_addr_2,
  input  logic                  ex_reg_write_enable,
  input  logic [REG_ADDR_W-1:0] ex_reg_write_addr,
  input  logic                  ex_is_load,
  input  logic                  mem_branch,
  input  logic                  mem_branch_direction,
  input  logic                  mem_zero,
  input  logic [XLEN-1:0]       mem_pc,
  input  logic [XLEN-1:0]       mem_branch_offset,
  output logic                  stall_flag,
  output logic                  branch_flag,
  output logic [XLEN-1:0]       redirect_pc,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  // Remaining-stall counter holds up to 6 (STALL_CYCLES <= 7)
  localparam int         REM_W        = 3;
  localparam logic [2:0] STALL_RELOAD = 3'(STALL_CYCLES - 1);
  localparam logic       MULTI_STALL  = (STALL_CYCLES > 1);

  hazard_state_t    state, next_state;
  logic [REM_W-1:0] remaining, next_remaining;

  logic             taken;
  logic             hazard;
  logic             stall_inc;
  logic             flush_inc;
  logic [CNT_W-1:0] stall_value;
  logic [CNT_W-1:0] flush_value;

  assign taken  = mem_branch & (mem_zero == mem_branch_direction);
  assign hazard = ex_is_load & ex_reg_write_enable &
                  (reg_dep(ex_reg_write_addr, id_read_addr_1) |
                   reg_dep(ex_reg_write_addr, id_read_addr_2));

  // Next-state, flag and counter-increment decode; branch wins over stall
  always_comb begin
    next_state     = state;
    next_remaining = remaining;
    stall_flag     = 1'b0;
    branch_flag    = 1'b0;
    redirect_pc    = '0;
    stall_inc      = 1'b0;
    flush_inc      = 1'b0;

    if (!rst) begin
      branch_flag = taken;
      if (taken) begin
        redirect_pc = mem_pc + mem_branch_offset;
      end

      unique case (state)
        RUN: begin
          if (taken) begin
            next_state = FLUSH;
            flush_inc  = 1'b1;
          end else if (hazard) begin
            stall_flag = 1'b1;
            stall_inc  = 1'b1;
            if (MULTI_STALL) begin
              next_remaining = STALL_RELOAD;
              next_state     = STALL;
            end
          end
        end
        STALL: begin
          // A taken branch squashes the stalled instruction anyway
          if (taken) begin
            next_state     = FLUSH;
            next_remaining = '0;
            flush_inc      = 1'b1;
          end else begin
            stall_flag     = 1'b1;
            stall_inc      = 1'b1;
            next_remaining = remaining - 1'b1;
            if (remaining == 3'd1) begin
              next_state = RUN;
            end
          end
        end
        FLUSH: begin
          // ID/EX hold bubbles this cycle, so hazard compares are meaningless
          if (taken) begin
            flush_inc = 1'b1;
          end else begin
            next_state = RUN;
          end
        end
        default: begin
          next_state     = RUN;
          next_remaining = '0;
        end
      endcase
    end
  end

  // State and remaining-stall registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      remaining <= '0;
    end else begin
      state     <= next_state;
      remaining <= next_remaining;
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .clear (1'b0),
    .value (stall_value)
  );

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .clear (1'b0),
    .value (flush_value)
  );

  // Counters read as zero throughout reset, including the first reset cycle
  assign stall_count = rst ? '0 : stall_value;
  assign flush_count = rst ? '0 : flush_value;

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_unit
// Description : Self-checking bench for hazard_unit. Three instances share
//               one stimulus stream (STALL_CYCLES=1, STALL_CYCLES=3, CNT_W=2);
//               every cycle each is compared to a behavioural model, plus a
//               directed vector table and hand-written corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ra1, ra2, wa;
  logic        we, ld, br, dir, zero;
  logic [31:0] pc, off;

  logic        s1, b1, s3, b3, ss, bs;
  logic [31:0] r1, r3, rs;
  logic [15:0] sc1, fc1, sc3, fc3;
  logic [1:0]  scs, fcs;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state per instance: bubbles still owed, flush-shadow, counters
  int SCP [3] = '{1, 3, 1};
  int CWP [3] = '{16, 16, 2};
  int rem [3];
  bit fl  [3];
  int msc [3];
  int mfc [3];

  always #5 clk = ~clk;

  hazard_unit #(.XLEN(32), .STALL_CYCLES(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .id_read_addr_1(ra1), .id_read_addr_2(ra2),
    .ex_reg_write_enable(we), .ex_reg_write_addr(wa), .ex_is_load(ld),
    .mem_branch(br), .mem_branch_direction(dir), .mem_zero(zero),
    .mem_pc(pc), .mem_branch_offset(off), .stall_flag(s1), .branch_flag(b1),
    .redirect_pc(r1), .stall_count(sc1), .flush_count(fc1));

  hazard_unit #(.XLEN(32), .STALL_CYCLES(3), .CNT_W(16)) u3 (
    .clk(clk), .rst(rst), .id_read_addr_1(ra1), .id_read_addr_2(ra2),
    .ex_reg_write_enable(we), .ex_reg_write_addr(wa), .ex_is_load(ld),
    .mem_branch(br), .mem_branch_direction(dir), .mem_zero(zero),
    .mem_pc(pc), .mem_branch_offset(off), .stall_flag(s3), .branch_flag(b3),
    .redirect_pc(r3), .stall_count(sc3), .flush_count(fc3));

  hazard_unit #(.XLEN(32), .STALL_CYCLES(1), .CNT_W(2)) us (
    .clk(clk), .rst(rst), .id_read_addr_1(ra1), .id_read_addr_2(ra2),
    .ex_reg_write_enable(we), .ex_reg_write_addr(wa), .ex_is_load(ld),
    .mem_branch(br), .mem_branch_direction(dir), .mem_zero(zero),
    .mem_pc(pc), .mem_branch_offset(off), .stall_flag(ss), .branch_flag(bs),
    .redirect_pc(rs), .stall_count(scs), .flush_count(fcs));

  typedef struct {
    logic        rst;
    logic [4:0]  ra1, ra2;
    logic        we;
    logic [4:0]  wa;
    logic        ld, br, dir, zero;
    logic [31:0] pc, off;
    logic        e_stall, e_branch;
    logic [31:0] e_redir;
    logic [15:0] e_sc, e_fc;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                       input logic w, input logic [4:0] d, input logic l,
                       input logic b, input logic di, input logic z,
                       input logic [31:0] p, input logic [31:0] o);
    rst = r; ra1 = a1; ra2 = a2; we = w; wa = d; ld = l;
    br = b; dir = di; zero = z; pc = p; off = o;
  endtask

  task automatic idle(input logic r);
    drive(r, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Wait to the falling edge and compare every instance against the model
  task automatic sample_check();
    logic        tk, hz;
    logic        e_s, a_s, a_b;
    logic [31:0] e_r, a_r, a_sc, a_fc;
    @(negedge clk);
    tk = br && (zero == dir);
    hz = ld && we && (wa != 0) && (wa == ra1 || wa == ra2);
    for (int d = 0; d < 3; d++) begin
      case (d)
        0: begin a_s = s1; a_b = b1; a_r = r1; a_sc = 32'(sc1); a_fc = 32'(fc1); end
        1: begin a_s = s3; a_b = b3; a_r = r3; a_sc = 32'(sc3); a_fc = 32'(fc3); end
        default: begin a_s = ss; a_b = bs; a_r = rs; a_sc = 32'(scs); a_fc = 32'(fcs); end
      endcase
      if (rst) begin
        e_s = 1'b0;
        e_r = 32'h0;
        check($sformatf("model u%0d branch", d), 32'(a_b), 32'h0);
      end else begin
        e_s = !tk && (rem[d] > 0 || (!fl[d] && hz));
        e_r = tk ? pc + off : 32'h0;
        check($sformatf("model u%0d branch", d), 32'(a_b), 32'(tk));
      end
      check($sformatf("model u%0d stall", d), 32'(a_s), 32'(e_s));
      check($sformatf("model u%0d redirect", d), a_r, e_r);
      check($sformatf("model u%0d stall_count", d), a_sc, rst ? 32'h0 : 32'(msc[d]));
      check($sformatf("model u%0d flush_count", d), a_fc, rst ? 32'h0 : 32'(mfc[d]));
    end
  endtask

  // Advance the model across the rising edge, then settle inputs after it
  task automatic advance();
    logic tk, hz;
    int   mx;
    tk = br && (zero == dir);
    hz = ld && we && (wa != 0) && (wa == ra1 || wa == ra2);
    @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      mx = (1 << CWP[d]) - 1;
      if (rst) begin
        rem[d] = 0; fl[d] = 1'b0; msc[d] = 0; mfc[d] = 0;
      end else if (tk) begin
        rem[d] = 0; fl[d] = 1'b1;
        if (mfc[d] < mx) mfc[d]++;
      end else if (rem[d] > 0) begin
        rem[d]--; fl[d] = 1'b0;
        if (msc[d] < mx) msc[d]++;
      end else if (!fl[d] && hz) begin
        rem[d] = SCP[d] - 1; fl[d] = 1'b0;
        if (msc[d] < mx) msc[d]++;
      end else begin
        fl[d] = 1'b0;
      end
    end
    #1;
  endtask

  task automatic step();
    sample_check();
    advance();
  endtask

  vec_t vt [15];

  function automatic vec_t mk(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                              input logic w, input logic [4:0] d, input logic l,
                              input logic b, input logic di, input logic z,
                              input logic [31:0] p, input logic [31:0] o,
                              input logic es, input logic eb, input logic [31:0] er,
                              input logic [15:0] esc, input logic [15:0] efc);
    vec_t v;
    v.rst = r; v.ra1 = a1; v.ra2 = a2; v.we = w; v.wa = d; v.ld = l;
    v.br = b; v.dir = di; v.zero = z; v.pc = p; v.off = o;
    v.e_stall = es; v.e_branch = eb; v.e_redir = er; v.e_sc = esc; v.e_fc = efc;
    return v;
  endfunction

  initial begin
    for (int d = 0; d < 3; d++) begin
      rem[d] = 0; fl[d] = 1'b0; msc[d] = 0; mfc[d] = 0;
    end
    idle(1'b1);

    // Directed table for the STALL_CYCLES=1 instance; counts are pre-edge
    //           rst  ra1   ra2   we  wa    ld  br  dir zero pc           off           stl brn redir        sc  fc
    vt[0]  = mk(1, 5'd5, 5'd5, 1, 5'd5, 1, 0, 0, 0, 32'h0,       32'h0,        0, 0, 32'h0,        0, 0);
    vt[1]  = mk(0, 5'd1, 5'd5, 1, 5'd5, 1, 0, 0, 0, 32'h0,       32'h0,        1, 0, 32'h0,        0, 0);
    vt[2]  = mk(0, 5'd1, 5'd2, 0, 5'd0, 0, 0, 0, 0, 32'h0,       32'h0,        0, 0, 32'h0,        1, 0);
    vt[3]  = mk(0, 5'd0, 5'd3, 1, 5'd0, 1, 0, 0, 0, 32'h0,       32'h0,        0, 0, 32'h0,        1, 0);
    vt[4]  = mk(0, 5'd7, 5'd3, 1, 5'd7, 0, 0, 0, 0, 32'h0,       32'h0,        0, 0, 32'h0,        1, 0);
    vt[5]  = mk(0, 5'd1, 5'd2, 0, 5'd0, 0, 1, 1, 1, 32'h100,     32'hFFFFFFF0, 0, 1, 32'h0F0,      1, 0);
    vt[6]  = mk(0, 5'd5, 5'd2, 1, 5'd5, 1, 0, 0, 0, 32'h0,       32'h0,        0, 0, 32'h0,        1, 1);
    vt[7]  = mk(0, 5'd1, 5'd2, 0, 5'd0, 0, 1, 0, 1, 32'h300,     32'h40,       0, 0, 32'h0,        1, 1);
    vt[8]  = mk(0, 5'd3, 5'd2, 1, 5'd3, 1, 1, 1, 1, 32'h200,     32'h8,        0, 1, 32'h208,      1, 1);
    vt[9]  = mk(0, 5'd3, 5'd2, 1, 5'd3, 1, 0, 1, 1, 32'h200,     32'h8,        0, 0, 32'h0,        1, 2);
    vt[10] = mk(0, 5'd4, 5'd9, 1, 5'd9, 1, 0, 0, 0, 32'h0,       32'h0,        1, 0, 32'h0,        1, 2);
    vt[11] = mk(0, 5'd9, 5'd4, 1, 5'd9, 1, 0, 0, 0, 32'h0,       32'h0,        1, 0, 32'h0,        2, 2);
    vt[12] = mk(0, 5'd1, 5'd2, 0, 5'd0, 0, 0, 0, 0, 32'h0,       32'h0,        0, 0, 32'h0,        3, 2);
    vt[13] = mk(1, 5'd1, 5'd2, 0, 5'd0, 0, 1, 1, 1, 32'h80,      32'h4,        0, 0, 32'h0,        0, 0);
    vt[14] = mk(0, 5'd1, 5'd2, 0, 5'd0, 0, 0, 0, 0, 32'h0,       32'h0,        0, 0, 32'h0,        0, 0);

    for (int i = 0; i < 15; i++) begin
      drive(vt[i].rst, vt[i].ra1, vt[i].ra2, vt[i].we, vt[i].wa, vt[i].ld,
            vt[i].br, vt[i].dir, vt[i].zero, vt[i].pc, vt[i].off);
      sample_check();
      check($sformatf("vec%0d stall", i), 32'(s1), 32'(vt[i].e_stall));
      check($sformatf("vec%0d branch", i), 32'(b1), 32'(vt[i].e_branch));
      check($sformatf("vec%0d redirect", i), r1, vt[i].e_redir);
      check($sformatf("vec%0d stall_count", i), 32'(sc1), 32'(vt[i].e_sc));
      check($sformatf("vec%0d flush_count", i), 32'(fc1), 32'(vt[i].e_fc));
      advance();
    end

    // STALL_CYCLES=3: branch on the 2nd stall cycle aborts the stall
    idle(1'b1); step();
    drive(0, 5'd1, 5'd5, 1, 5'd5, 1, 0, 0, 0, 32'h0, 32'h0);
    sample_check();
    check("abort c1 stall", 32'(s3), 32'h1);
    check("abort c1 branch", 32'(b3), 32'h0);
    advance();
    drive(0, 5'd1, 5'd5, 1, 5'd5, 1, 1, 1, 1, 32'h40, 32'h4);
    sample_check();
    check("abort c2 stall", 32'(s3), 32'h0);
    check("abort c2 branch", 32'(b3), 32'h1);
    advance();
    idle(1'b0);
    sample_check();
    check("abort flush stall", 32'(s3), 32'h0);
    check("abort stall_count", 32'(sc3), 32'h1);
    check("abort flush_count", 32'(fc3), 32'h1);
    advance();
    // Back in RUN: a fresh hazard stalls, and the stall holds without hazard
    drive(0, 5'd6, 5'd1, 1, 5'd6, 1, 0, 0, 0, 32'h0, 32'h0);
    sample_check();
    check("run after flush stall", 32'(s3), 32'h1);
    advance();
    idle(1'b0);
    sample_check();
    check("stall holds", 32'(s3), 32'h1);
    advance();
    // Reset mid-stall
    idle(1'b1);
    sample_check();
    check("rst mid-stall stall", 32'(s3), 32'h0);
    check("rst mid-stall count", 32'(sc3), 32'h0);
    advance();
    idle(1'b0);
    sample_check();
    check("post-rst stall", 32'(s3), 32'h0);
    check("post-rst branch", 32'(b3), 32'h0);
    check("post-rst stall_count", 32'(sc3), 32'h0);
    check("post-rst flush_count", 32'(fc3), 32'h0);
    advance();
    drive(0, 5'd8, 5'd1, 1, 5'd8, 1, 0, 0, 0, 32'h0, 32'h0);
    sample_check();
    check("post-rst run hazard", 32'(s3), 32'h1);
    advance();
    idle(1'b0);
    for (int i = 0; i < 3; i++) step();

    // Saturation: five isolated hazards on a 2-bit counter
    idle(1'b1); step();
    for (int i = 0; i < 5; i++) begin
      drive(0, 5'd10, 5'd1, 1, 5'd10, 1, 0, 0, 0, 32'h0, 32'h0);
      step();
      idle(1'b0);
      step();
    end
    sample_check();
    check("sat stall_count cnt2", 32'(scs), 32'h3);
    check("sat stall_count cnt16", 32'(sc1), 32'h5);
    advance();

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) == 0),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom, $urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
